// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard control bundle: pipe-register fields in, ID control strobes out.
// The slave side is the hazard controller, the master side is the pipeline around it.
interface id_hazard_ctrl_if #(
   parameter int REG_W = 5
);
   logic [6:0]       id_opcode;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic [6:0]       ex_opcode;
   logic [REG_W-1:0] ex_rd;
   logic [6:0]       wb_opcode;
   logic [REG_W-1:0] wb_rd;
   logic             br_taken;
   logic             mem_stall;
   logic             load_regfile;
   logic             bubble;
   logic             w_en;
   logic [REG_W-1:0] dest;
   logic [1:0]       adder_mux;
   logic             busy;

   modport slave (
      input  id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd, wb_opcode, wb_rd,
             br_taken, mem_stall,
      output load_regfile, bubble, w_en, dest, adder_mux, busy
   );

   modport master (
      output id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd, wb_opcode, wb_rd,
             br_taken, mem_stall,
      input  load_regfile, bubble, w_en, dest, adder_mux, busy
   );
endinterface

// File: rtl/id_hazard_ctrl.sv
// RV32I decode-stage control: write-back enable, branch adder select, load-use stall
// and post-branch squash sequencing for the IF/ID and ID/EX registers.
module id_hazard_ctrl #(
   parameter int SQUASH_CYCLES   = 2,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int REG_W           = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   id_hazard_ctrl_if.slave bus
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [REG_W-1:0] X0      = '0;
   localparam logic [2:0]       SQ_INIT = 3'(SQUASH_CYCLES - 1);
   localparam logic [2:0]       ST_INIT = 3'(LOAD_USE_CYCLES - 1);

   typedef enum logic [1:0] {RUN, STALL, SQUASH} state_t;

   state_t     state;
   logic [2:0] sq_cnt;
   logic [2:0] st_cnt;

   logic rs1_used;
   logic rs2_used;
   logic hazard;
   logic wb_writes;
   logic load_regfile_c;
   logic bubble_c;
   logic [1:0] adder_mux_c;

   assign rs1_used = !(bus.id_opcode == OP_LUI || bus.id_opcode == OP_AUIPC ||
                       bus.id_opcode == OP_JAL);
   assign rs2_used = (bus.id_opcode == OP_REG || bus.id_opcode == OP_BR ||
                      bus.id_opcode == OP_STORE);
   assign hazard   = (bus.ex_opcode == OP_LOAD) && (bus.ex_rd != X0) &&
                     ((rs1_used && bus.id_rs1 == bus.ex_rd) ||
                      (rs2_used && bus.id_rs2 == bus.ex_rd));

   always_comb begin
      wb_writes = 1'b0;
      case (bus.wb_opcode)
         OP_IMM, OP_LUI, OP_LOAD, OP_AUIPC, OP_JAL, OP_JALR, OP_REG: wb_writes = 1'b1;
         default: wb_writes = 1'b0;
      endcase
   end

   always_comb begin
      adder_mux_c = 2'b00;
      if (bus.id_opcode == OP_BR)
         adder_mux_c = 2'b10;
      else if (bus.id_opcode == OP_JAL)
         adder_mux_c = 2'b01;
   end

   // Strobes react in the same cycle as the event; a frozen pipe neither loads nor bubbles.
   always_comb begin
      load_regfile_c = 1'b1;
      bubble_c       = 1'b0;
      if (!rst_n) begin
         load_regfile_c = 1'b0;
         bubble_c       = 1'b1;
      end else if (bus.mem_stall) begin
         load_regfile_c = 1'b0;
         bubble_c       = 1'b0;
      end else if (bus.br_taken) begin
         load_regfile_c = 1'b1;
         bubble_c       = 1'b1;
      end else begin
         case (state)
            SQUASH: begin
               load_regfile_c = 1'b1;
               bubble_c       = 1'b1;
            end
            STALL: begin
               load_regfile_c = 1'b0;
               bubble_c       = 1'b1;
            end
            default: begin
               if (hazard) begin
                  load_regfile_c = 1'b0;
                  bubble_c       = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= RUN;
         sq_cnt <= 3'd0;
         st_cnt <= 3'd0;
      end else if (bus.mem_stall) begin
         state  <= state;
      end else if (bus.br_taken) begin
         st_cnt <= 3'd0;
         sq_cnt <= SQ_INIT;
         state  <= (SQUASH_CYCLES > 1) ? SQUASH : RUN;
      end else begin
         case (state)
            SQUASH: begin
               if (sq_cnt != 3'd0)
                  sq_cnt <= sq_cnt - 3'd1;
               if (sq_cnt <= 3'd1)
                  state <= RUN;
            end
            STALL: begin
               if (st_cnt != 3'd0)
                  st_cnt <= st_cnt - 3'd1;
               if (st_cnt <= 3'd1)
                  state <= RUN;
            end
            RUN: begin
               if (hazard && LOAD_USE_CYCLES > 1) begin
                  state  <= STALL;
                  st_cnt <= ST_INIT;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.load_regfile = load_regfile_c;
   assign bus.bubble       = bubble_c;
   assign bus.w_en         = rst_n && wb_writes && (bus.wb_rd != X0);
   assign bus.dest         = bus.wb_rd;
   assign bus.adder_mux    = adder_mux_c;
   assign bus.busy         = rst_n && (state != RUN);
endmodule
